// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-back queue.
package regfile_pkg;

   localparam int WB_DEPTH = 4;
   localparam int WB_AW    = 4;
   localparam int WB_DW    = 32;

   localparam logic [WB_AW-1:0] REG_PC = 4'hF;

   typedef struct packed {
      logic [WB_AW-1:0] addr;
      logic [WB_DW-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match search over the queue storage for one read address.
module wb_fwd_match
   import regfile_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH,
   parameter int PW    = $clog2(WB_DEPTH),
   parameter int AW    = WB_AW,
   parameter int DW    = WB_DW
) (
   input  wb_entry_t [DEPTH-1:0] i_mem,
   input  logic [DEPTH-1:0]      i_vld,
   input  logic [PW-1:0]         i_wp,
   input  logic [AW-1:0]         i_ra,
   output logic                  o_hit,
   output logic [DW-1:0]         o_data
);

   logic [PW-1:0] w_idx;

   // Walk oldest to youngest so the last match overwrites earlier ones.
   always_comb begin
      o_hit  = 1'b0;
      o_data = '0;
      w_idx  = '0;
      for (int k = DEPTH; k >= 1; k--) begin
         w_idx = i_wp - k[PW-1:0];
         if (i_vld[w_idx] && (i_mem[w_idx].addr == i_ra) &&
             (i_ra != REG_PC)) begin
            o_hit  = 1'b1;
            o_data = i_mem[w_idx].data;
         end
      end
   end

endmodule

// File: rtl/regfile_wb_queue.sv
// In-order write-back queue feeding the regfile write port,
// with youngest-value forwarding for two decode read addresses.
module regfile_wb_queue
   import regfile_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH,
   parameter int AW    = WB_AW,
   parameter int DW    = WB_DW,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_data,
   input  logic          hold,
   output logic          we3,
   output logic [AW-1:0] wa3,
   output logic [DW-1:0] wd3,
   input  logic [AW-1:0] ra1,
   input  logic [AW-1:0] ra2,
   output logic          fwd1_hit,
   output logic [DW-1:0] fwd1_data,
   output logic          fwd2_hit,
   output logic [DW-1:0] fwd2_data,
   output logic [CW-1:0] count
);

   wb_entry_t [DEPTH-1:0] r_mem;
   logic [DEPTH-1:0]      r_vld;
   logic [PW-1:0]         r_wp;
   logic [PW-1:0]         r_rp;
   logic [CW-1:0]         r_count;

   logic      w_nempty;
   logic      w_pop;
   logic      w_push;
   wb_entry_t w_head;

   assign w_head    = r_mem[r_rp];
   assign w_nempty  = (r_count != '0);
   assign w_pop     = w_nempty & ~hold;
   assign req_ready = (r_count < CW'(DEPTH)) | w_pop;
   // The PC has no storage: complete the handshake but drop the write.
   assign w_push    = req_valid & req_ready & (req_addr != REG_PC);

   assign we3   = w_pop;
   assign wa3   = w_nempty ? w_head.addr : '0;
   assign wd3   = w_nempty ? w_head.data : '0;
   assign count = r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mem   <= '0;
         r_vld   <= '0;
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
      end else begin
         if (w_pop) begin
            r_vld[r_rp] <= 1'b0;
            r_rp        <= r_rp + PW'(1);
         end
         if (w_push) begin
            r_mem[r_wp] <= '{addr: req_addr, data: req_data};
            r_vld[r_wp] <= 1'b1;
            r_wp        <= r_wp + PW'(1);
         end
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   wb_fwd_match #(
      .DEPTH(DEPTH), .PW(PW), .AW(AW), .DW(DW)
   ) u_fwd1 (
      .i_mem (r_mem),
      .i_vld (r_vld),
      .i_wp  (r_wp),
      .i_ra  (ra1),
      .o_hit (fwd1_hit),
      .o_data(fwd1_data)
   );

   wb_fwd_match #(
      .DEPTH(DEPTH), .PW(PW), .AW(AW), .DW(DW)
   ) u_fwd2 (
      .i_mem (r_mem),
      .i_vld (r_vld),
      .i_wp  (r_wp),
      .i_ra  (ra2),
      .o_hit (fwd2_hit),
      .o_data(fwd2_data)
   );

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Randomized and directed bench for regfile_wb_queue against a queue-based model.
module tb_regfile_wb_queue;

   localparam int DEPTH = 4;
   localparam int AW    = 4;
   localparam int DW    = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_data;
   logic          hold;
   logic          we3;
   logic [AW-1:0] wa3;
   logic [DW-1:0] wd3;
   logic [AW-1:0] ra1;
   logic [AW-1:0] ra2;
   logic          fwd1_hit;
   logic [DW-1:0] fwd1_data;
   logic          fwd2_hit;
   logic [DW-1:0] fwd2_data;
   logic [2:0]    count;

   int checks = 0;
   int errors = 0;
   bit cmp_on = 1'b0;

   always #5 clk = ~clk;

   regfile_wb_queue dut (
      .clk      (clk),
      .reset    (reset),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_addr (req_addr),
      .req_data (req_data),
      .hold     (hold),
      .we3      (we3),
      .wa3      (wa3),
      .wd3      (wd3),
      .ra1      (ra1),
      .ra2      (ra2),
      .fwd1_hit (fwd1_hit),
      .fwd1_data(fwd1_data),
      .fwd2_hit (fwd2_hit),
      .fwd2_data(fwd2_data),
      .count    (count)
   );

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Reference model: pending writes, oldest at index 0.
   typedef struct {
      logic [3:0]  a;
      logic [31:0] d;
   } ent_t;

   ent_t mq[$];

   function automatic void model_fwd(input logic [3:0] ra,
                                     output bit hit,
                                     output logic [31:0] d);
      hit = 1'b0;
      d   = '0;
      if (ra != 4'hF) begin
         for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].a == ra) begin
               hit = 1'b1;
               d   = mq[i].d;
               break;
            end
         end
      end
   endfunction

   always @(posedge clk or posedge reset) begin : model_upd
      bit m_pop;
      bit m_rdy;
      ent_t e;
      if (reset) begin
         mq.delete();
      end else begin
         m_pop = (mq.size() != 0) && !hold;
         m_rdy = (mq.size() < DEPTH) || m_pop;
         if (m_pop) void'(mq.pop_front());
         if (req_valid && m_rdy && (req_addr != 4'hF)) begin
            e.a = req_addr;
            e.d = req_data;
            mq.push_back(e);
         end
      end
   end

   always @(negedge clk) begin : compare
      int          n;
      bit          e_pop;
      bit          h1;
      bit          h2;
      logic [31:0] d1;
      logic [31:0] d2;
      if (cmp_on) begin
         n     = mq.size();
         e_pop = (n != 0) && !hold;
         model_fwd(ra1, h1, d1);
         model_fwd(ra2, h2, d2);
         chk("m_count", count, n);
         chk("m_we3", we3, e_pop);
         chk("m_wa3", wa3, (n != 0) ? mq[0].a : 4'h0);
         chk("m_wd3", wd3, (n != 0) ? mq[0].d : 32'h0);
         chk("m_ready", req_ready, (n < DEPTH) || e_pop);
         chk("m_fwd1_hit", fwd1_hit, h1);
         chk("m_fwd1_data", fwd1_data, d1);
         chk("m_fwd2_hit", fwd2_hit, h2);
         chk("m_fwd2_data", fwd2_data, d2);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [3:0]  t2a[4];
   logic [31:0] t2d[4];

   initial begin
      t2a = '{4'h1, 4'h2, 4'h1, 4'h5};
      t2d = '{32'hA, 32'hB, 32'hC, 32'hD};
      reset     = 1'b1;
      req_valid = 1'b0;
      req_addr  = '0;
      req_data  = '0;
      hold      = 1'b0;
      ra1       = '0;
      ra2       = '0;
      cmp_on    = 1'b1;
      repeat (2) step();
      chk("rst_we3", we3, 0);
      chk("rst_count", count, 0);
      chk("rst_ready", req_ready, 1);
      chk("rst_fwd1_hit", fwd1_hit, 0);
      reset = 1'b0;

      // single write, one-cycle latency
      req_valid = 1'b1;
      req_addr  = 4'h3;
      req_data  = 32'h11;
      step();
      req_valid = 1'b0;
      #1;
      chk("t1_we3", we3, 1);
      chk("t1_wa3", wa3, 3);
      chk("t1_wd3", wd3, 32'h11);
      chk("t1_count", count, 1);
      step();
      chk("t1_idle_we3", we3, 0);
      chk("t1_idle_count", count, 0);

      // fill under hold, forward youngest, drain in order
      hold      = 1'b1;
      req_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_addr = t2a[i];
         req_data = t2d[i];
         step();
      end
      req_valid = 1'b0;
      ra1 = 4'h1;
      ra2 = 4'h2;
      #1;
      chk("t2_count", count, 4);
      chk("t2_ready", req_ready, 0);
      chk("t2_fwd1_hit", fwd1_hit, 1);
      chk("t2_fwd1_data", fwd1_data, 32'hC);
      chk("t2_fwd2_data", fwd2_data, 32'hB);
      hold = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("t2_drain_we3", we3, 1);
         chk("t2_drain_wa3", wa3, t2a[i]);
         chk("t2_drain_wd3", wd3, t2d[i]);
         step();
      end
      chk("t2_done_we3", we3, 0);
      chk("t2_done_count", count, 0);

      // full with simultaneous push and pop
      hold      = 1'b1;
      req_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_addr = 4'($urandom_range(0, 14));
         req_data = $urandom;
         step();
      end
      hold = 1'b0;
      for (int i = 0; i < 12; i++) begin
         req_addr = 4'($urandom_range(0, 14));
         req_data = $urandom;
         ra1      = 4'($urandom_range(0, 15));
         ra2      = 4'($urandom_range(0, 15));
         #1;
         chk("t3_ready", req_ready, 1);
         chk("t3_count", count, 4);
         step();
      end
      req_valid = 1'b0;
      repeat (5) step();
      chk("t3_empty", count, 0);

      // PC writes are swallowed
      req_valid = 1'b1;
      req_addr  = 4'hF;
      req_data  = 32'hFFFF;
      ra1       = 4'hF;
      #1;
      chk("t4_ready", req_ready, 1);
      step();
      req_valid = 1'b0;
      #1;
      chk("t4_count", count, 0);
      chk("t4_we3", we3, 0);
      chk("t4_fwd1_hit", fwd1_hit, 0);

      // async reset while entries are pending
      hold      = 1'b1;
      req_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         req_addr = 4'(6 + i);
         req_data = 32'h100 + i;
         step();
      end
      req_valid = 1'b0;
      ra1 = 4'h7;
      #1;
      chk("t5_pre_count", count, 3);
      chk("t5_pre_hit", fwd1_hit, 1);
      #1;
      reset = 1'b1;
      #1;
      chk("t5_count", count, 0);
      chk("t5_wa3", wa3, 0);
      chk("t5_wd3", wd3, 0);
      chk("t5_fwd1_hit", fwd1_hit, 0);
      chk("t5_fwd1_data", fwd1_data, 0);
      #2;
      reset = 1'b0;
      hold  = 1'b0;
      step();
      chk("t5_post_we3", we3, 0);
      step();
      chk("t5_post2_we3", we3, 0);

      // hit during drain, gone afterwards
      req_valid = 1'b1;
      req_addr  = 4'h4;
      req_data  = 32'h5;
      ra1       = 4'h4;
      step();
      req_valid = 1'b0;
      #1;
      chk("t6_we3", we3, 1);
      chk("t6_hit", fwd1_hit, 1);
      chk("t6_data", fwd1_data, 32'h5);
      step();
      chk("t6_after_hit", fwd1_hit, 0);
      chk("t6_after_data", fwd1_data, 0);

      // random traffic with varying hold pressure
      for (int blk = 0; blk < 15; blk++) begin
         int hp;
         hp = $urandom_range(0, 3);
         for (int i = 0; i < 200; i++) begin
            reset     = ($urandom_range(0, 299) == 0);
            hold      = ($urandom_range(0, 3) < hp);
            req_valid = ($urandom_range(0, 2) != 0);
            req_addr  = 4'($urandom_range(0, 15));
            req_data  = $urandom;
            ra1       = 4'($urandom_range(0, 15));
            ra2       = 4'($urandom_range(0, 15));
            step();
         end
      end
      reset     = 1'b0;
      hold      = 1'b0;
      req_valid = 1'b0;
      repeat (6) step();
      chk("end_count", count, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
